// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - Data-side bus responder: byte-lane RAM plus memory-mapped timer
//
// Purpose: answers the single-cycle CPU's data port. It decodes each access
// to a word RAM, a 4-register timer block, or unmapped space. Reads are
// combinational; writes land on the rising clock edge.
//
// Ports:
//   iCLK           clock, rising-edge
//   iRST           asynchronous active-high reset (timer and error flag only)
//   DwReadEnable   read strobe
//   DwWriteEnable  write strobe
//   DwByteEnable   byte lanes, bit n selects DwWriteData[8n+7:8n]
//   DwAddress      byte address, bits [1:0] ignored
//   DwWriteData    write data
//   DwReadData     read data, 0 when not reading or unmapped
//   oIRQ           timer interrupt (MATCH & IRQEN)
//   oBusErr        high for the cycle after an unmapped access
module data_bus_responder #(
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
  parameter logic [31:0] MMIO_BASE = 32'hFF20_0000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        DwReadEnable,
  input  logic        DwWriteEnable,
  input  logic [3:0]  DwByteEnable,
  input  logic [31:0] DwAddress,
  input  logic [31:0] DwWriteData,
  output logic [31:0] DwReadData,
  output logic        oIRQ,
  output logic        oBusErr
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic [31:0] ram [0:RAM_WORDS-1];

  logic [2:0]  ctrl;      // {IRQEN, AUTORELOAD, EN}
  logic [31:0] count;
  logic [31:0] compare;
  logic        match;
  logic        bus_err;

  logic [2:0]  ctrl_nxt;
  logic [31:0] count_nxt;
  logic [31:0] compare_nxt;
  logic        match_nxt;
  logic        bus_err_nxt;

  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [1:0]    reg_sel;
  logic          mmio_wr;
  logic          cmp_hit;

  // The word-address bits are never decoded.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^DwAddress[1:0];

  // RAM_BASE is aligned to the RAM size, so an upper-bit compare is the
  // same as the range test [RAM_BASE, RAM_BASE + RAM_WORDS*4).
  assign ram_hit  = (DwAddress[31:AW+2] == RAM_BASE[31:AW+2]);
  assign mmio_hit = (DwAddress[31:4] == MMIO_BASE[31:4]);
  assign ram_idx  = DwAddress[AW+1:2];
  assign reg_sel  = DwAddress[3:2];

  // Timer registers accept only full-word writes.
  assign mmio_wr  = DwWriteEnable && mmio_hit && (DwByteEnable == 4'hF);
  assign cmp_hit  = ctrl[0] && (count == compare);

  // RAM has no reset, so its contents survive iRST.
  always_ff @(posedge iCLK) begin
    if (!iRST && DwWriteEnable && ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (DwByteEnable[b]) begin
          ram[ram_idx][8*b +: 8] <= DwWriteData[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    ctrl_nxt    = ctrl;
    count_nxt   = count;
    compare_nxt = compare;
    match_nxt   = match;
    bus_err_nxt = (DwReadEnable || DwWriteEnable) && !ram_hit && !mmio_hit;

    if (ctrl[0]) begin
      count_nxt = (cmp_hit && ctrl[1]) ? 32'd0 : count + 32'd1;
    end

    if (mmio_wr) begin
      case (reg_sel)
        REG_CTRL:    ctrl_nxt    = DwWriteData[2:0];
        REG_COUNT:   count_nxt   = DwWriteData;
        REG_COMPARE: compare_nxt = DwWriteData;
        REG_STATUS:  if (DwWriteData[0]) match_nxt = 1'b0;
        default:     ;
      endcase
    end

    // A match on the same edge as a W1C clear wins.
    if (cmp_hit) begin
      match_nxt = 1'b1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ctrl    <= 3'd0;
      count   <= 32'd0;
      compare <= 32'hFFFF_FFFF;
      match   <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      ctrl    <= ctrl_nxt;
      count   <= count_nxt;
      compare <= compare_nxt;
      match   <= match_nxt;
      bus_err <= bus_err_nxt;
    end
  end

  always_comb begin
    DwReadData = 32'h0;
    if (DwReadEnable) begin
      if (ram_hit) begin
        DwReadData = ram[ram_idx];
      end else if (mmio_hit) begin
        case (reg_sel)
          REG_CTRL:    DwReadData = {29'd0, ctrl};
          REG_COUNT:   DwReadData = count;
          REG_COMPARE: DwReadData = compare;
          REG_STATUS:  DwReadData = {31'd0, match};
          default:     DwReadData = 32'h0;
        endcase
      end
    end
  end

  assign oIRQ    = match & ctrl[2];
  assign oBusErr = bus_err;

endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - Randomized self-checking bench for data_bus_responder
module tb_data_bus_responder;

  localparam int unsigned RAM_WORDS = 256;
  localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE = 32'hFF20_0000;
  localparam logic [31:0] RAM_END   = RAM_BASE + RAM_WORDS * 4;
  localparam logic [31:0] A_CTRL    = MMIO_BASE + 0;
  localparam logic [31:0] A_COUNT   = MMIO_BASE + 4;
  localparam logic [31:0] A_CMP     = MMIO_BASE + 8;
  localparam logic [31:0] A_STAT    = MMIO_BASE + 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [3:0]  be;
  logic [31:0] addr, wd;
  logic [31:0] rdata;
  logic        irq, berr;

  data_bus_responder #(
    .RAM_WORDS(RAM_WORDS), .RAM_BASE(RAM_BASE), .MMIO_BASE(MMIO_BASE)
  ) dut (
    .iCLK(clk), .iRST(rst),
    .DwReadEnable(rd), .DwWriteEnable(wr), .DwByteEnable(be),
    .DwAddress(addr), .DwWriteData(wd), .DwReadData(rdata),
    .oIRQ(irq), .oBusErr(berr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: memory-map view of the device.
  logic [31:0] m_ram [RAM_WORDS];
  logic [2:0]  m_ctrl;
  logic [31:0] m_count, m_cmp;
  logic        m_match, m_berr;
  logic [31:0] g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic void m_reset();
    m_ctrl = 3'd0; m_count = 32'd0; m_cmp = 32'hFFFF_FFFF; m_match = 1'b0; m_berr = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a >= RAM_BASE && a < RAM_END) return m_ram[(a - RAM_BASE) >> 2];
    if ((a >> 4) == (MMIO_BASE >> 4)) begin
      case ((a >> 2) & 32'd3)
        32'd0:   return {29'd0, m_ctrl};
        32'd1:   return m_count;
        32'd2:   return m_cmp;
        default: return {31'd0, m_match};
      endcase
    end
    return 32'd0;
  endfunction

  // Advance the model by one clock edge given the bus access seen before it.
  function automatic void m_step(input logic r, input logic w, input logic [3:0] b,
                                 input logic [31:0] a, input logic [31:0] d);
    logic in_ram, in_mmio, full;
    logic [31:0] sel;
    logic [2:0]  nctrl;
    logic [31:0] ncount, ncmp;
    logic        nmatch;
    in_ram  = (a >= RAM_BASE && a < RAM_END);
    in_mmio = ((a >> 4) == (MMIO_BASE >> 4));
    full    = w && in_mmio && (b == 4'hF);
    sel     = (a >> 2) & 32'd3;
    nctrl = m_ctrl; ncount = m_count; ncmp = m_cmp; nmatch = m_match;
    if (full && sel == 0) nctrl = d[2:0];
    if (full && sel == 2) ncmp = d;
    if (full && sel == 3 && d[0]) nmatch = 1'b0;
    if (m_ctrl[0]) begin
      if (m_count == m_cmp) begin
        nmatch = 1'b1;
        ncount = m_ctrl[1] ? 32'd0 : m_count + 32'd1;
      end else begin
        ncount = m_count + 32'd1;
      end
    end
    if (full && sel == 1) ncount = d;
    if (w && in_ram) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) m_ram[(a - RAM_BASE) >> 2][8*k +: 8] = d[8*k +: 8];
    end
    m_berr  = (r || w) && !in_ram && !in_mmio;
    m_ctrl  = nctrl; m_count = ncount; m_cmp = ncmp; m_match = nmatch;
  endfunction

  task automatic bus_op(input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
    @(negedge clk);
    rd = r; wr = w; be = b; addr = a; wd = d;
    #1;
    got = rdata;
    chk("rdata", rdata, r ? m_read(a) : 32'd0);
    @(posedge clk);
    m_step(r, w, b, a, d);
    #1;
    chk("irq", irq, {31'd0, m_ctrl[2] & m_match});
    chk("buserr", berr, {31'd0, m_berr});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rd = 0; wr = 0; be = 0; addr = 0; wd = 0;
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_seq [$];
    logic [3:0]  rb;
    logic [31:0] ra, rwd;
    int kind;
    bit found;

    rst = 1'b1; rd = 0; wr = 0; be = 0; addr = 0; wd = 0;
    m_reset();

    // Reset values, observed combinationally while reset is held.
    @(posedge clk); @(negedge clk);
    rd = 1; addr = A_CTRL;  #1 chk("rst_ctrl", rdata, 32'd0);
    addr = A_COUNT;         #1 chk("rst_count", rdata, 32'd0);
    addr = A_CMP;           #1 chk("rst_cmp", rdata, 32'hFFFF_FFFF);
    addr = A_STAT;          #1 chk("rst_stat", rdata, 32'd0);
    chk("rst_irq", irq, 32'd0);
    chk("rst_berr", berr, 32'd0);
    // A write during reset must be ignored.
    rd = 0; wr = 1; be = 4'hF; addr = A_CMP; wd = 32'd7;
    @(posedge clk); @(negedge clk);
    rst = 0; wr = 0;
    bus_op(1, 0, 4'h0, A_CMP, 0, g);
    chk("rst_wr_ignored", g, 32'hFFFF_FFFF);

    // Give every RAM word a known value.
    for (int i = 0; i < RAM_WORDS; i++)
      bus_op(0, 1, 4'hF, RAM_BASE + i * 4, $urandom, g);

    // Byte-lane merge.
    bus_op(0, 1, 4'hF, RAM_BASE + 8, 32'hDEAD_BEEF, g);
    bus_op(0, 1, 4'b0010, RAM_BASE + 8, 32'h0000_5500, g);
    bus_op(1, 0, 4'h0, RAM_BASE + 8, 0, g);
    chk("byte_lane", g, 32'hDEAD_55EF);

    // Auto-reload sequence, MATCH and IRQ.
    do_reset();
    bus_op(0, 1, 4'hF, A_CMP, 32'd5, g);
    bus_op(0, 1, 4'hF, A_CTRL, 32'd3, g);
    exp_seq = '{0, 1, 2, 3, 4, 5, 0, 1};
    foreach (exp_seq[i]) begin
      bus_op(1, 0, 4'h0, A_COUNT, 0, g);
      chk("autoreload_seq", g, exp_seq[i]);
    end
    bus_op(1, 0, 4'h0, A_STAT, 0, g);
    chk("match_set", g, 32'd1);
    bus_op(0, 1, 4'hF, A_CTRL, 32'd7, g);
    chk("irq_on", irq, 32'd1);
    bus_op(0, 1, 4'hF, A_STAT, 32'd1, g);
    chk("irq_cleared", irq, 32'd0);

    // 32-bit wrap without reload.
    do_reset();
    bus_op(0, 1, 4'hF, A_COUNT, 32'hFFFF_FFFE, g);
    bus_op(0, 1, 4'hF, A_CMP, 32'd3, g);
    bus_op(0, 1, 4'hF, A_CTRL, 32'd1, g);
    exp_seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1, 2, 3, 4};
    foreach (exp_seq[i]) begin
      bus_op(1, 0, 4'h0, A_COUNT, 0, g);
      chk("wrap_seq", g, exp_seq[i]);
    end
    bus_op(1, 0, 4'h0, A_STAT, 0, g);
    chk("wrap_match", g, 32'd1);
    bus_op(0, 1, 4'hF, A_STAT, 32'd1, g);
    for (int i = 0; i < 4; i++) bus_op(0, 0, 4'h0, 0, 0, g);
    bus_op(1, 0, 4'h0, A_STAT, 0, g);
    chk("match_once", g, 32'd0);

    // Unmapped read and partial-lane MMIO write.
    do_reset();
    bus_op(1, 0, 4'h0, 32'h0000_0000, 0, g);
    chk("unmapped_rdata", g, 32'd0);
    chk("berr_set", berr, 32'd1);
    bus_op(0, 0, 4'h0, 0, 0, g);
    chk("berr_one_cycle", berr, 32'd0);
    bus_op(0, 1, 4'h3, A_COUNT, 32'h0000_1234, g);
    bus_op(1, 0, 4'h0, A_COUNT, 0, g);
    chk("partial_mmio_wr", g, 32'd0);

    // Match beats same-cycle W1C; COUNT write beats increment.
    do_reset();
    bus_op(0, 1, 4'hF, A_CMP, 32'd3, g);
    bus_op(0, 1, 4'hF, A_CTRL, 32'd1, g);
    for (int i = 0; i < 3; i++) bus_op(1, 0, 4'h0, A_COUNT, 0, g);
    bus_op(0, 1, 4'hF, A_STAT, 32'd1, g);
    bus_op(1, 0, 4'h0, A_STAT, 0, g);
    chk("match_over_w1c", g, 32'd1);
    bus_op(0, 1, 4'hF, A_COUNT, 32'd1000, g);
    bus_op(1, 0, 4'h0, A_COUNT, 0, g);
    chk("count_wr_override", g, 32'd1000);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      rb   = 4'($urandom);
      rwd  = $urandom;
      if (kind <= 5) begin
        ra = RAM_BASE + ($urandom_range(0, RAM_WORDS - 1) << 2) + $urandom_range(0, 3);
      end else if (kind <= 8) begin
        ra = MMIO_BASE + $urandom_range(0, 15);
        if ($urandom_range(0, 3) != 0) rb = 4'hF;
        if ($urandom_range(0, 3) != 0) rwd = $urandom_range(0, 63);
      end else begin
        ra = {4'h2, 28'($urandom)};
      end
      bus_op(1'($urandom), 1'($urandom), rb, ra, rwd, g);
    end

    // Asynchronous reset mid-count; RAM survives.
    do_reset();
    bus_op(0, 1, 4'hF, RAM_BASE, 32'hA5A5_1234, g);
    bus_op(0, 1, 4'hF, A_CMP, 32'd50, g);
    bus_op(0, 1, 4'hF, A_CTRL, 32'd5, g);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      bus_op(1, 0, 4'h0, A_COUNT, 0, g);
      if (g == 32'd100) found = 1;
    end
    if (!found) chk("count100_timeout", 32'd0, 32'd1);
    chk("irq_before_rst", irq, 32'd1);
    @(negedge clk);
    rd = 1; wr = 0; addr = A_COUNT;
    #1 rst = 1'b1;
    #1 chk("async_rst_count", rdata, 32'd0);
    chk("async_rst_irq", irq, 32'd0);
    addr = A_CTRL;
    #1 chk("async_rst_ctrl", rdata, 32'd0);
    m_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    bus_op(1, 0, 4'h0, RAM_BASE, 0, g);
    chk("ram_retained", g, 32'hA5A5_1234);
    bus_op(1, 0, 4'h0, A_COUNT, 0, g);
    bus_op(1, 0, 4'h0, A_COUNT, 0, g);
    chk("stays_disabled", g, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 Parameter RAM_WORDS, default 256, SHALL set the data RAM depth in 32-bit words (power of two, 16..4096).
REQ-002 Parameter RAM_BASE, default 32'h1001_0000, SHALL set the RAM base byte address (aligned to RAM_WORDS*4).
REQ-003 Parameter MMIO_BASE, default 32'hFF20_0000, SHALL set the timer register block base (16-byte window).
REQ-004 Clocking: iCLK input, 1 bit, clock; all state updates on its rising edge.
REQ-005 Reset: iRST input, 1 bit, asynchronous, active-high.
REQ-006 DwReadEnable input, 1 bit, read strobe from the datapath.
REQ-007 DwWriteEnable input, 1 bit, write strobe from the datapath.
REQ-008 DwByteEnable input, 4 bits, byte lanes; bit n selects DwWriteData[8n+7:8n].
REQ-009 DwAddress input, 32 bits, byte address; bits [1:0] ignored (word access).
REQ-010 DwWriteData input, 32 bits, write data.
REQ-011 DwReadData output, 32 bits, read data returned to the datapath.
REQ-012 oIRQ output, 1 bit, timer interrupt request.
REQ-013 oBusErr output, 1 bit, registered unmapped-access flag.

Function
REQ-014 Decode: RAM hit when DwAddress in [RAM_BASE, RAM_BASE+RAM_WORDS*4); MMIO hit when DwAddress[31:4]==MMIO_BASE[31:4]; otherwise unmapped.
REQ-015 Reads SHALL be combinational (same cycle, single-cycle CPU): DwReadData = selected word when DwReadEnable=1 and hit, else 32'h0.
REQ-016 RAM write on rising iCLK when DwWriteEnable=1 and RAM hit; only lanes with DwByteEnable bit set change.
REQ-017 MMIO registers (offset DwAddress[3:2]): 0 CTRL {bit0 EN, bit1 AUTORELOAD, bit2 IRQEN, others read 0}; 1 COUNT; 2 COMPARE; 3 STATUS {bit0 MATCH, others read 0}.
REQ-018 MMIO writes SHALL take effect only when DwByteEnable==4'hF; partial-lane MMIO writes ignored, no error.
REQ-019 COUNT SHALL increment by 1 each iCLK while EN=1, wrapping 32'hFFFF_FFFF -> 0.
REQ-020 When EN=1 and COUNT==COMPARE at a clock edge: MATCH set to 1; next COUNT = 0 if AUTORELOAD=1, else COUNT+1.
REQ-021 Writing STATUS with bit0=1 SHALL clear MATCH (write-1-to-clear); bit0=0 no effect.
REQ-022 Simultaneous events: bus write to COUNT overrides increment/reload; match set overrides same-cycle W1C clear.
REQ-023 oIRQ = MATCH & IRQEN, combinational from registered state.
REQ-024 oBusErr SHALL be 1 for exactly the cycle after any unmapped access (read or write enable high); writes to unmapped space change no state.
REQ-025 DwReadEnable and DwWriteEnable both high: write occurs at edge; read data reflects pre-edge contents.
REQ-026 RAM contents SHALL NOT be cleared by reset (undefined at power-up in simulation, X allowed).

Reset
REQ-027 While iRST=1: CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, MATCH=0, oBusErr=0, oIRQ=0; bus writes ignored.
REQ-028 Reset asserted mid-count SHALL stop counting immediately; after release the timer stays disabled until CTRL written.

Verification
REQ-029 RAM write 32'hDEAD_BEEF at RAM_BASE+8, BE=4'hF, then BE=4'b0010 data 32'h0000_5500 -> read RAM_BASE+8 returns 32'hDEAD_55EF.
REQ-030 COMPARE=5, CTRL=3 (EN,AUTORELOAD) -> COUNT sequence 0..5,0,1..; MATCH=1 from edge after COUNT==5; with IRQEN set, oIRQ=1; STATUS write 1 -> oIRQ=0.
REQ-031 COUNT written 32'hFFFF_FFFE, CTRL=1, COMPARE=3 -> FFFF_FFFF, 0, 1, 2, 3, 4; MATCH set once.
REQ-032 Read 32'h0000_0000 (unmapped) -> DwReadData=0, oBusErr=1 for one cycle; MMIO COUNT write with BE=4'h3 -> COUNT unchanged.
REQ-033 Same-cycle match and STATUS W1C -> MATCH remains 1; COUNT write during EN=1 -> written value loaded, no increment that cycle.
REQ-034 iRST pulse at COUNT=100, EN=1 -> COUNT=0, CTRL=0, oIRQ=0 asynchronously; RAM word at RAM_BASE retains previous value.
